// File: rtl/rx_pkt_filter_1000_pkg.sv
// rx_pkt_filter_1000_pkg: 139-bit word types, FSM states and filter limits.
// Shared by the receive filter and the transmit-side 139-bit stages.
package rx_pkt_filter_1000_pkg;

    localparam int WORD_W = 139;

    localparam logic [2:0] TYPE_HEAD = 3'b101;
    localparam logic [2:0] TYPE_BODY = 3'b100;
    localparam logic [2:0] TYPE_TAIL = 3'b110;

    localparam logic [6:0] MAX_WORDS = 7'd96;
    localparam logic [7:0] USEDW_MAX = 8'd160;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DROP,
        ST_RESYNC
    } state_t;

    function automatic logic [2:0] word_type(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: 3];
    endfunction

endpackage

// File: rtl/rx_pkt_filter_1000.sv
// rx_pkt_filter_1000: admits good packets from the GMII-to-139 converter,
// drops bad-flagged ones and closes malformed or over-long packets as bad.
module rx_pkt_filter_1000
    import rx_pkt_filter_1000_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_q,
    input  logic              data_empty,
    output logic              data_rdreq,
    input  logic              flag_q,
    input  logic              flag_empty,
    output logic              flag_rdreq,
    output logic              out_data_wrreq,
    output logic [WORD_W-1:0] out_data,
    input  logic [7:0]        out_data_usedw,
    output logic              out_valid_wrreq,
    output logic              out_valid,
    output logic              pkt_forward,
    output logic              pkt_drop
);

    state_t state_q;
    state_t state_d;
    logic [6:0] cnt_q;
    logic [6:0] cnt_d;

    logic [2:0] wtype;
    logic is_head;
    logic is_tail;
    logic first_word;
    logic malformed;

    logic flag_pop;
    logic data_pop;
    logic xfer_pop;

    logic wr_d;
    logic vwr_d;
    logic valid_d;
    logic drop_d;
    logic [WORD_W-1:0] data_d;

    assign wtype      = word_type(data_q);
    assign is_head    = (wtype == TYPE_HEAD);
    assign is_tail    = (wtype == TYPE_TAIL);
    assign first_word = (cnt_q == 7'd0);

    // A packet must open with head (or a lone tail), carry no second
    // head, and close by its MAX_WORDS-th word.
    assign malformed = (first_word && !is_head && !is_tail)
                     || (!first_word && is_head)
                     || ((cnt_q == MAX_WORDS - 7'd1) && !is_tail);

    // State and per-packet word counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: flag decision in IDLE, tail or malformed exits elsewhere
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (flag_pop) begin
                    state_d = flag_q ? ST_XFER : ST_DROP;
                end
            end
            ST_XFER: begin
                if (data_pop) begin
                    cnt_d = cnt_q + 7'd1;
                    if (malformed) begin
                        state_d = is_tail ? ST_IDLE : ST_RESYNC;
                    end else if (is_tail) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP, ST_RESYNC: begin
                if (data_pop && is_tail) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: upstream pops plus next values of the write stage
    always_comb begin
        flag_pop = 1'b0;
        data_pop = 1'b0;
        if (reset) begin
            flag_pop = (state_q == ST_IDLE) && !flag_empty
                     && (out_data_usedw < USEDW_MAX);
            data_pop = (state_q != ST_IDLE) && !data_empty;
        end
        xfer_pop = data_pop && (state_q == ST_XFER);
        wr_d     = xfer_pop;
        vwr_d    = xfer_pop && (is_tail || malformed);
        valid_d  = xfer_pop && is_tail && !malformed;
        drop_d   = (xfer_pop && malformed)
                 || (data_pop && (state_q == ST_DROP) && is_tail);
        data_d   = data_q;
        if (malformed) begin
            data_d[WORD_W-1 -: 3] = TYPE_TAIL;
        end
    end

    assign flag_rdreq = flag_pop;
    assign data_rdreq = data_pop;

    // Registered write stage, exactly one cycle behind the pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_wrreq  <= 1'b0;
            out_data        <= '0;
            out_valid_wrreq <= 1'b0;
            out_valid       <= 1'b0;
            pkt_forward     <= 1'b0;
            pkt_drop        <= 1'b0;
        end else begin
            out_data_wrreq  <= wr_d;
            out_valid_wrreq <= vwr_d;
            out_valid       <= valid_d;
            pkt_forward     <= valid_d;
            pkt_drop        <= drop_d;
            if (wr_d) begin
                out_data <= data_d;
            end
        end
    end

endmodule

// File: doc/rx_pkt_filter_1000.md
# rx_pkt_filter_1000

Packet admission stage directly downstream of the 1000M GMII-to-139-bit receive converter, on the receive side of the port. It drains the converter's packet data FIFO and per-packet valid-flag FIFO, forwards complete good packets into the next stage's data/flag FIFO pair, and silently discards packets flagged bad. It also guards against malformed or over-long packets.

## Interface
- MAX_WORDS, 7'd96: maximum 139-bit words per packet; 1518 B needs 95 words.
- USEDW_MAX, 8'd160: start a packet only if `out_data_usedw` < this value, which guarantees room for a MAX_WORDS packet in a 256-deep downstream FIFO.

Ports:
- clk  in  1  single clock domain for all logic.
- reset  in  1  asynchronous, active-low reset.
- data_q  in  139  head of upstream data FIFO (show-ahead).
- data_empty  in  1  upstream data FIFO empty.
- data_rdreq  out  1  pop upstream data FIFO.
- flag_q  in  1  head of upstream flag FIFO: 1 = good packet, 0 = bad packet.
- flag_empty  in  1  upstream flag FIFO empty.
- flag_rdreq  out  1  pop upstream flag FIFO.
- out_data_wrreq  out  1  write to downstream data FIFO.
- out_data  out  139  word written downstream.
- out_data_usedw  in  8  downstream data FIFO fill level.
- out_valid_wrreq  out  1  write to downstream flag FIFO.
- out_valid  out  1  flag written downstream.
- pkt_forward  out  1  one-cycle pulse per forwarded good packet.
- pkt_drop  out  1  one-cycle pulse per discarded packet (bad flag or malformed).

## Operation
Word format:
- [138:136] word type: 101 = head, 100 = body, 110 = tail.
- [135:132] count of invalid bytes in the tail word.
- [131:0] reserved/data.
- A single-word packet uses type 110 and is treated as head+tail.

A flag entry exists only once its whole packet is in the data FIFO, so data never runs dry mid-packet. An empty data FIFO mid-packet is still tolerated as a stall.

States:
- IDLE: if `!flag_empty && out_data_usedw < USEDW_MAX`, assert `flag_rdreq` for one cycle. Go to XFER if `flag_q` = 1, else DROP.
- XFER: each cycle with `!data_empty`, assert `data_rdreq`. The popped word appears on `out_data` with `out_data_wrreq` one cycle later, and the word counter increments.
  - On a tail word, `out_valid_wrreq` = 1, `out_valid` = 1 and `pkt_forward` = 1 in the same cycle as that word's write, then return to IDLE.
- DROP: pop words while `!data_empty`, with no downstream writes. On popping the tail, pulse `pkt_drop` next cycle and return to IDLE.
- Malformed packet while in XFER. This applies when either:
  - the first word is not head or tail, or a head arrives after the first word; or
  - the counter reaches MAX_WORDS without a tail.

  Required behaviour:
  - The offending word is written downstream with [138:136] forced to 110, `out_valid` = 0 and `out_valid_wrreq` = 1, so downstream sees a closed bad packet.
  - Pulse `pkt_drop`, not `pkt_forward`.
  - Enter RESYNC, unless the offending word was a tail, in which case go to IDLE.
- RESYNC: pop and discard words until a tail is popped, then go to IDLE. A new head in RESYNC is also discarded.
- No downstream backpressure is checked mid-packet; the admission threshold covers it.

## Timing
- Reset: every output is 0, the state is IDLE and the counter is 0.
- Latency: `data_rdreq` to `out_data_wrreq` is exactly 1 cycle, registered. Throughput is 1 word/clk.
- Flag decision: the IDLE → XFER/DROP transition takes 1 cycle. The first `data_rdreq` is no earlier than the cycle after `flag_rdreq`.
- Minimum back-to-back gap: tail write, then 1 IDLE cycle, then the next packet's first pop.
- `out_valid_wrreq` coincides with the tail's `out_data_wrreq`, never before it.
- If `out_data_usedw` is at or above USEDW_MAX in IDLE, wait with no pops.
- If reset is asserted mid-packet, the FSM aborts immediately with no further writes. Downstream FIFOs are reset by the same net.

## Structure
- Shared package: word-type constants (`TYPE_HEAD` = 3'b101, `TYPE_BODY` = 3'b100, `TYPE_TAIL` = 3'b110), the FSM state encoding, and the MAX_WORDS/USEDW_MAX defaults, which are shared with the transmit-side 139-bit stages.
- Single module, no sub-modules. A natural split is one FSM block plus one registered output stage.

## Test plan
- Good 5-word packet (head, 3 body, tail with [135:132] = 4), flag 1 → 5 writes on consecutive cycles, data identical; `out_valid_wrreq` and `pkt_forward` on the 5th write with `out_valid` = 1.
- Bad 3-word packet, flag 0 → 3 pops, 0 data writes, 0 flag writes, one `pkt_drop` pulse.
- Single tail-only word, flag 1 → 1 write plus flag write `out_valid` = 1; next packet's first pop occurs 2 cycles after this one's.
- `out_data_usedw` = 160 with a flag pending → no `flag_rdreq`; drop usedw to 159 → `flag_rdreq` the next cycle.
- 100-word packet without a tail, flag 1 → 96 writes, the 96th typed 110 with `out_valid` = 0, `pkt_drop` = 1; remaining words are discarded through the tail, then the next packet forwards normally.
- Reset pulsed after 2 words of a 6-word packet → all outputs 0 within the reset cycle, FSM in IDLE, no `out_valid_wrreq`.
